// File: rtl/ahb_cmd_master.sv
// Single-outstanding command-to-AHB-Lite master: accept -> NONSEQ address -> data -> response, 4 cycles min.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready, slave waits bounded by TIMEOUT.
module ahb_cmd_master #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [CW-1:0] r_cnt;
  logic          r_err_seen;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic          w_cmd_hs;
  logic          w_misalign;
  logic          w_timeout;

  assign w_cmd_hs   = cmd_valid && (r_state == S_IDLE);
  assign w_misalign = (cmd_addr[1:0] != 2'b00);
  assign w_timeout  = (r_state == S_DATA) && !HREADY && (r_cnt == TMO_LAST);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_cmd_hs) w_next = w_misalign ? S_RESP : S_ADDR;
      S_ADDR: if (HREADY) w_next = S_DATA;
      S_DATA: if (HREADY || w_timeout) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_write    <= 1'b0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_cnt      <= '0;
      r_err_seen <= 1'b0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_write <= cmd_write;
        r_addr  <= cmd_addr;
        r_wdata <= cmd_wdata;
        if (w_misalign) begin
          r_rdata <= ERR_DATA;
          r_err   <= 1'b1;
        end
      end
      if ((r_state == S_ADDR) && HREADY) begin
        r_cnt      <= '0;
        r_err_seen <= 1'b0;
      end
      // An ERROR response starts with HREADY low, so HRESP is remembered across wait cycles.
      if (r_state == S_DATA) begin
        if (HRESP) r_err_seen <= 1'b1;
        if (HREADY) begin
          r_rdata <= r_write ? 32'h0 : HRDATA;
          r_err   <= r_err_seen | HRESP;
        end else if (w_timeout) begin
          r_rdata <= ERR_DATA;
          r_err   <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign HSEL      = (r_state == S_ADDR);
  assign HTRANS    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR     = r_addr;
  assign HWRITE    = r_write;
  assign HSIZE     = 3'b010;
  assign HWDATA    = ((r_state == S_DATA) && r_write) ? r_wdata : 32'h0;

endmodule
